// File: rtl/baccarat_pkg.sv
// Shared baccarat card definitions: widths, rank constants and the rank-to-value mapping.
package baccarat_pkg;

  localparam int unsigned CARD_W    = 4;
  localparam int unsigned NUM_RANKS = 13;
  localparam int unsigned RANK_ACE  = 1;
  localparam int unsigned RANK_KING = 13;

  typedef logic [CARD_W-1:0] card_t;

  // Ranks 1..9 count face value; 10/J/Q/K and the empty slot (0) count zero.
  function automatic card_t card_value(card_t card);
    if ((card >= card_t'(1)) && (card <= card_t'(9))) begin
      return card;
    end
    return '0;
  endfunction

endpackage

// File: rtl/score_hand.sv
// Three-card baccarat hand score: sum of card values modulo 10, purely combinational.
module score_hand
  import baccarat_pkg::*;
(
  input  card_t card_a_i,
  input  card_t card_b_i,
  input  card_t card_c_i,
  output card_t score_o
);

  logic [4:0] sum;
  logic [4:0] mod10;

  always_comb begin
    sum = 5'(card_value(card_a_i)) + 5'(card_value(card_b_i)) + 5'(card_value(card_c_i));
    // Sum never exceeds 27, so at most two subtractions of ten are needed.
    if (sum >= 5'd20) begin
      mod10 = sum - 5'd20;
    end else if (sum >= 5'd10) begin
      mod10 = sum - 5'd10;
    end else begin
      mod10 = sum;
    end
    score_o = card_t'(mod10);
  end

endmodule

// File: rtl/card_datapath.sv
// Baccarat deal datapath: rank generator, six card registers, deal counter and hand scores.
// Optional CARD_INJECT_EN adds inject_en/inject_card to force the captured card value.
module card_datapath
  import baccarat_pkg::*;
#(
  parameter int unsigned SEED = 1
) (
  input  logic              slow_clock,
  input  logic              resetb,
  input  logic              load_pcard1,
  input  logic              load_pcard2,
  input  logic              load_pcard3,
  input  logic              load_dcard1,
  input  logic              load_dcard2,
  input  logic              load_dcard3,
`ifdef CARD_INJECT_EN
  input  logic              inject_en,
  input  logic [CARD_W-1:0] inject_card,
`endif
  output logic [CARD_W-1:0] pcard1,
  output logic [CARD_W-1:0] pcard2,
  output logic [CARD_W-1:0] pcard3,
  output logic [CARD_W-1:0] dcard1,
  output logic [CARD_W-1:0] dcard2,
  output logic [CARD_W-1:0] dcard3,
  output logic [CARD_W-1:0] pcard3_val,
  output logic [CARD_W-1:0] pscore,
  output logic [CARD_W-1:0] dscore,
  output logic [2:0]        cards_dealt
);

  card_t      gen_q, gen_d;
  card_t      card_src;
  card_t      pcard1_q, pcard2_q, pcard3_q;
  card_t      dcard1_q, dcard2_q, dcard3_q;
  logic [2:0] cards_dealt_q, cards_dealt_d;
  logic       any_load;

  always_comb begin
    if (gen_q == card_t'(NUM_RANKS)) begin
      gen_d = card_t'(RANK_ACE);
    end else begin
      gen_d = gen_q + card_t'(1);
    end
  end

`ifdef CARD_INJECT_EN
  assign card_src = inject_en ? inject_card : gen_q;
`else
  assign card_src = gen_q;
`endif

  assign any_load = load_pcard1 | load_pcard2 | load_pcard3 |
                    load_dcard1 | load_dcard2 | load_dcard3;

  // One count per load edge regardless of how many registers it writes.
  always_comb begin
    cards_dealt_d = cards_dealt_q;
    if (any_load && (cards_dealt_q != 3'd6)) begin
      cards_dealt_d = cards_dealt_q + 3'd1;
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      gen_q         <= card_t'(SEED);
      cards_dealt_q <= 3'd0;
    end else begin
      gen_q         <= gen_d;
      cards_dealt_q <= cards_dealt_d;
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      pcard1_q <= '0;
      pcard2_q <= '0;
      pcard3_q <= '0;
      dcard1_q <= '0;
      dcard2_q <= '0;
      dcard3_q <= '0;
    end else begin
      if (load_pcard1) pcard1_q <= card_src;
      if (load_pcard2) pcard2_q <= card_src;
      if (load_pcard3) pcard3_q <= card_src;
      if (load_dcard1) dcard1_q <= card_src;
      if (load_dcard2) dcard2_q <= card_src;
      if (load_dcard3) dcard3_q <= card_src;
    end
  end

  score_hand u_player_score (
    .card_a_i (pcard1_q),
    .card_b_i (pcard2_q),
    .card_c_i (pcard3_q),
    .score_o  (pscore)
  );

  score_hand u_dealer_score (
    .card_a_i (dcard1_q),
    .card_b_i (dcard2_q),
    .card_c_i (dcard3_q),
    .score_o  (dscore)
  );

  assign pcard1      = pcard1_q;
  assign pcard2      = pcard2_q;
  assign pcard3      = pcard3_q;
  assign dcard1      = dcard1_q;
  assign dcard2      = dcard2_q;
  assign dcard3      = dcard3_q;
  assign pcard3_val  = card_value(pcard3_q);
  assign cards_dealt = cards_dealt_q;

endmodule

// File: tb/tb_card_datapath.sv
// Directed bench for card_datapath: generator sequence, loads, scores, saturation and reset.
module tb_card_datapath;

  logic       clk;
  logic       resetb;
  logic       ld_p1, ld_p2, ld_p3, ld_d1, ld_d2, ld_d3;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [3:0] pcard3_val, pscore, dscore;
  logic [2:0] cards_dealt;

  int passed;
  int total;

  // Bench-side model: generator, cards {d3,d2,d1,p3,p2,p1}, deal count.
  int gen_m;
  int card_m [6];
  int cnt_m;

  card_datapath #(.SEED(1)) dut (
    .slow_clock  (clk),
    .resetb      (resetb),
    .load_pcard1 (ld_p1),
    .load_pcard2 (ld_p2),
    .load_pcard3 (ld_p3),
    .load_dcard1 (ld_d1),
    .load_dcard2 (ld_d2),
    .load_dcard3 (ld_d3),
`ifdef CARD_INJECT_EN
    .inject_en   (1'b0),
    .inject_card (4'd0),
`endif
    .pcard1      (pcard1),
    .pcard2      (pcard2),
    .pcard3      (pcard3),
    .dcard1      (dcard1),
    .dcard2      (dcard2),
    .dcard3      (dcard3),
    .pcard3_val  (pcard3_val),
    .pscore      (pscore),
    .dscore      (dscore),
    .cards_dealt (cards_dealt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int mval(input int r);
    return (r >= 1 && r <= 9) ? r : 0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".pcard1"}, int'(pcard1), card_m[0]);
    check({tag, ".pcard2"}, int'(pcard2), card_m[1]);
    check({tag, ".pcard3"}, int'(pcard3), card_m[2]);
    check({tag, ".dcard1"}, int'(dcard1), card_m[3]);
    check({tag, ".dcard2"}, int'(dcard2), card_m[4]);
    check({tag, ".dcard3"}, int'(dcard3), card_m[5]);
    check({tag, ".pcard3_val"}, int'(pcard3_val), mval(card_m[2]));
    check({tag, ".pscore"}, int'(pscore),
          (mval(card_m[0]) + mval(card_m[1]) + mval(card_m[2])) % 10);
    check({tag, ".dscore"}, int'(dscore),
          (mval(card_m[3]) + mval(card_m[4]) + mval(card_m[5])) % 10);
    check({tag, ".cards_dealt"}, int'(cards_dealt), cnt_m);
  endtask

  // Called from negedge; applies loads for one rising edge, then checks at the next negedge.
  task automatic step(input string tag, input logic [5:0] ld);
    {ld_d3, ld_d2, ld_d1, ld_p3, ld_p2, ld_p1} = ld;
    @(posedge clk);
    @(negedge clk);
    {ld_d3, ld_d2, ld_d1, ld_p3, ld_p2, ld_p1} = 6'b0;
    for (int i = 0; i < 6; i++) begin
      if (ld[i]) card_m[i] = gen_m;
    end
    if (ld != 6'b0 && cnt_m < 6) cnt_m++;
    gen_m = (gen_m == 13) ? 1 : gen_m + 1;
    check_all(tag);
  endtask

  // Idles until the model generator shows the rank, then loads it.
  task automatic load_rank(input string tag, input int rank, input logic [5:0] ld);
    for (int k = 0; k < 13 && gen_m != rank; k++) step({tag, ".idle"}, 6'b0);
    check({tag, ".reach"}, gen_m, rank);
    step(tag, ld);
  endtask

  // Called from negedge; asserts reset between edges and checks clearing before any edge.
  task automatic do_reset(input string tag);
    #2 resetb = 1'b0;
    #1;
    gen_m = 1;
    cnt_m = 0;
    for (int i = 0; i < 6; i++) card_m[i] = 0;
    check_all(tag);
    @(negedge clk);
    resetb = 1'b1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    resetb = 1'b0;
    {ld_d3, ld_d2, ld_d1, ld_p3, ld_p2, ld_p1} = 6'b0;
    @(negedge clk);
    do_reset("rst0");

    // Generator reads 1,2,3 after reset.
    step("gen1", 6'b000001);
    check("gen1.hand", int'(pcard1), 1);
    step("gen2", 6'b000001);
    check("gen2.hand", int'(pcard1), 2);
    step("gen3", 6'b000001);
    check("gen3.hand", int'(pcard1), 3);
    check("gen3.cnt", int'(cards_dealt), 3);

    // 14 consecutive samples: wrap 13 -> 1, never 0 or 14.
    do_reset("rst1");
    for (int i = 0; i < 14; i++) begin
      step("wrap", 6'b000001);
      check("wrap.hand", int'(pcard1), (i % 13) + 1);
      check("wrap.range", int'(pcard1 >= 4'd1 && pcard1 <= 4'd13), 1);
    end
    check("wrap.sat", int'(cards_dealt), 6);

    // Hand scores from timed generator loads.
    do_reset("rst2");
    load_rank("p1_9", 9, 6'b000001);
    load_rank("p2_8", 8, 6'b000010);
    check("pscore_9_8", int'(pscore), 7);
    load_rank("d1_K", 13, 6'b001000);
    load_rank("d2_5", 5, 6'b010000);
    check("dscore_K_5", int'(dscore), 5);
    load_rank("p3_4", 4, 6'b000100);
    check("pcard3_val_4", int'(pcard3_val), 4);
    check("pscore_9_8_4", int'(pscore), 1);
    load_rank("d3_Q", 12, 6'b100000);
    check("dscore_K_5_Q", int'(dscore), 5);

    // Simultaneous loads on one edge.
    do_reset("rst3");
    load_rank("dual6", 6, 6'b001001);
    check("dual6.p1", int'(pcard1), 6);
    check("dual6.d1", int'(dcard1), 6);
    check("dual6.cnt", int'(cards_dealt), 1);

    // Seven separate loads: count sticks at 6, seventh still overwrites.
    do_reset("rst4");
    step("sat1", 6'b000001);
    step("sat2", 6'b000010);
    step("sat3", 6'b000100);
    step("sat4", 6'b001000);
    step("sat5", 6'b010000);
    step("sat6", 6'b100000);
    check("sat6.cnt", int'(cards_dealt), 6);
    step("sat7", 6'b000001);
    check("sat7.cnt", int'(cards_dealt), 6);
    check("sat7.p1", int'(pcard1), 7);
    check("sat7.dscore", int'(dscore), 5);

    // Mid-hand asynchronous reset, then first card equals SEED.
    do_reset("rst5");
    step("mid1", 6'b000001);
    step("mid2", 6'b000010);
    step("mid3", 6'b001000);
    step("mid4", 6'b010000);
    check("mid4.cnt", int'(cards_dealt), 4);
    do_reset("midrst");
    check("midrst.pscore", int'(pscore), 0);
    step("post", 6'b000001);
    check("post.seed", int'(pcard1), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
